fg_wave_shaper: RTL
===================

Name: fg_wave_shaper

Overview:
- Downstream stage of the function-generator timer.
- Consumes the timer's counter/phase value and its sample strobe, and turns the phase into a waveform sample: square, sawtooth, triangle or sine.
- Applies amplitude scaling and an offset, saturates the result, and presents an unsigned DAC code with a one-cycle valid pulse.
- Fully pipelined: 3-cycle latency, throughput of 1 sample/cycle.

Parameters:
- PHASE_BITWIDTH, 10, width of the phase input; must be >= DATA_BITWIDTH+2.
- DATA_BITWIDTH, 8, width of the output sample and of the signed offset.
- AMP_BITWIDTH, 8, amplitude fraction bits; 2^AMP_BITWIDTH = unity gain.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- enable_i  in  1  1 = accept samples; 0 = ignore phase_valid_i.
- phase_i  in  PHASE_BITWIDTH  phase from the timer counter output.
- phase_valid_i  in  1  sample strobe from the timer clock-enable output.
- mode_i  in  2  0 square, 1 sawtooth, 2 triangle, 3 sine.
- duty_i  in  PHASE_BITWIDTH  square-wave high threshold.
- amp_i  in  AMP_BITWIDTH+1  unsigned gain; 256 = 1.0, 511 ≈ 2.0.
- offset_i  in  DATA_BITWIDTH  signed offset added after scaling.
- data_o  out  DATA_BITWIDTH  unsigned DAC code, held between samples.
- valid_o  out  1  one-cycle pulse when data_o updates.

Behaviour:
Reset (rst_i = 1, async):
- All pipeline registers and valid bits cleared.
- data_o = 2^(DATA_BITWIDTH-1) (midscale, 128).
- valid_o = 0.
- Reset mid-stream drops in-flight samples.

Accept and latency:
- A sample is accepted when phase_valid_i && enable_i.
- valid_o pulses exactly 3 cycles after acceptance.
- Back-to-back accepts every cycle are supported.
- When nothing is accepted, data_o holds its last value and valid_o = 0.

Stage 1 (waveform):
- mode_i, duty_i and amp_i are sampled with the phase and travel down the pipeline, so each sample is coherent with its own configuration.
- Define D = DATA_BITWIDTH, P = PHASE_BITWIDTH, t = phase[P-1 -: D]. The signed D-bit waveform w is:
  - Square: w = (phase < duty) ? 2^(D-1)-1 : -2^(D-1). duty = 0 gives always low.
  - Sawtooth: w = t - 2^(D-1) (t with its MSB inverted).
  - Triangle: u = phase[P-2 -: D]. If phase MSB = 0, v = u; otherwise v = ~u. Then w = v - 2^(D-1).
  - Sine: quadrant q = phase[P-1:P-2], index i = phase[P-3:0]. If q[0] = 1, i is bit-inverted (mirrored). The magnitude m is read from a registered quarter-wave ROM holding round((2^(D-1)-1)·sin(π/2·(i+0.5)/2^(P-2))). w = q[1] ? -m : m.

Stage 2 (scale):
- s = (w · $signed({0, amp})) >>> AMP_BITWIDTH, arithmetic shift (floor).
- Full-width product; no intermediate truncation.
- offset_i is registered alongside s.

Stage 3 (offset and saturate):
- r = s + 2^(D-1) + sign-extended offset.
- Clamp r to [0, 2^D - 1], then register into data_o and assert valid_o.
- Both clamp limits are reachable with amp > 256 or a nonzero offset.

Optional Feature:
FG_SINE_EN:
- Defined: mode 3 produces sine through the fg_sine_lut ROM instance.
- Undefined: the ROM is not instantiated, mode 3 behaves exactly like triangle, and latency is unchanged.

Decomposition:
- Shared package fg_pkg:
  - mode encodings: MODE_SQUARE=0, MODE_SAW=1, MODE_TRI=2, MODE_SINE=3.
  - AMP_UNITY constant.
  - Default width constants shared with the timer.
- One sub-module, fg_sine_lut:
  - input: a (P-2)-bit index; output: a (D-1)-bit magnitude.
  - Synchronous read with 1-cycle latency, aligned with stage 1.
  - ROM contents generated at elaboration.

Test Plan:
All cases use D=8, P=10, amp=256, offset=0 unless stated.
1. rst_i asserted asynchronously mid-stream -> data_o=128 and valid_o=0 immediately; no further valid_o pulses until new accepts.
2. Square, duty=512: phase 100 -> data_o=255; phase 600 -> data_o=0; each valid_o arrives 3 cycles after its accept.
3. Sawtooth, amp=511, offset=+100: phase 1020 -> 255 (upper clamp). Sawtooth, amp=511, offset=0: phase 0 -> 0 (lower clamp, s=-256).
4. Triangle: phase 0 -> 0; phase 511 -> 255; phase 512 -> 255; phase 1023 -> 0.
5. Sine (FG_SINE_EN defined): phase 0 -> 128; phase 256 -> 255; phase 768 -> 1. Same case without FG_SINE_EN -> matches triangle values.
6. phase_valid_i high for 8 consecutive cycles with enable_i dropped after 4 -> exactly 4 valid_o pulses; data_o holds the last value afterwards.

Source files
------------

// File: rtl/fg_pkg.sv
// Shared definitions for the function-generator blocks: waveform mode
// encodings, unity-gain constant and default widths shared with the timer.
package fg_pkg;

    // Default widths shared with the timer
    localparam int FG_PHASE_BW = 10;
    localparam int FG_DATA_BW  = 8;
    localparam int FG_AMP_BW   = 8;

    // Gain value that leaves the waveform unscaled
    localparam int AMP_UNITY = 1 << FG_AMP_BW;

    // Waveform mode encodings
    localparam logic [1:0] MODE_SQUARE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_SINE   = 2'd3;

endpackage

// File: rtl/fg_wave_shaper_sine_lut.sv
// fg_sine_lut: quarter-wave sine magnitude ROM with a registered read.
// Entry i holds round((2^MAG-1) * sin(pi/2 * (i+0.5) / 2^IDX)); contents are
// computed at elaboration. One cycle of read latency.
module fg_sine_lut #(
    parameter int IDX_BITWIDTH = 8,
    parameter int MAG_BITWIDTH = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [IDX_BITWIDTH-1:0] idx_i,
    output logic [MAG_BITWIDTH-1:0] mag_o
);

    localparam int N = 1 << IDX_BITWIDTH;

    function automatic logic [MAG_BITWIDTH-1:0] sine_mag(input int idx);
        real full;
        real ang;
        full = real'((1 << MAG_BITWIDTH) - 1);
        ang  = 3.141592653589793 / 2.0 * (real'(idx) + 0.5) / real'(N);
        return MAG_BITWIDTH'($rtoi(full * $sin(ang) + 0.5));
    endfunction

    logic [MAG_BITWIDTH-1:0] rom [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        assign rom[g] = sine_mag(g);
    end

    // Registered ROM read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) mag_o <= '0;
        else       mag_o <= rom[idx_i];
    end

endmodule

// File: rtl/fg_wave_shaper.sv
// fg_wave_shaper: turns the timer phase into a square / sawtooth / triangle /
// sine sample, applies gain and offset, saturates, and outputs an unsigned DAC
// code. Three register stages: waveform, scale, offset+clamp.
// Optional feature macro: FG_SINE_EN (sine ROM for mode 3; otherwise mode 3
// produces the triangle wave with identical latency).
//
// Handshake: a sample is accepted on a rising clk_i edge where
// phase_valid_i && enable_i. There is no back-pressure; one sample per cycle
// may be accepted. valid_o is high for exactly one cycle, three cycles after
// the accept, and data_o only changes in that cycle (held otherwise).
module fg_wave_shaper
    import fg_pkg::*;
#(
    parameter int PHASE_BITWIDTH = FG_PHASE_BW,
    parameter int DATA_BITWIDTH  = FG_DATA_BW,
    parameter int AMP_BITWIDTH   = FG_AMP_BW
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic [PHASE_BITWIDTH-1:0] phase_i,
    input  logic                      phase_valid_i,
    input  logic [1:0]                mode_i,
    input  logic [PHASE_BITWIDTH-1:0] duty_i,
    input  logic [AMP_BITWIDTH:0]     amp_i,
    input  logic [DATA_BITWIDTH-1:0]  offset_i,
    output logic [DATA_BITWIDTH-1:0]  data_o,
    output logic                      valid_o
);

    localparam int P = PHASE_BITWIDTH;
    localparam int D = DATA_BITWIDTH;
    localparam int A = AMP_BITWIDTH;
    localparam logic [D+2:0] MID = (D+3)'(1 << (D-1));

    logic         accept;
    logic [D-1:0] t_c, u_c, v_c, w_c;

    // Stage 1 registers
    logic         v1;
    logic [D-1:0] w1;
    logic [A:0]   amp1;
    logic [D-1:0] ws1;

    // Stage 2 registers
    logic                 v2;
    logic [D+1:0]         s2;
    logic [D-1:0]         off2;
    logic signed [D+A+1:0] prod;

    logic [D+2:0] r_c;

    assign accept = phase_valid_i && enable_i;

    // Non-sine waveform from the incoming phase (mode 3 falls back to triangle)
    always_comb begin
        t_c = phase_i[P-1 -: D];
        u_c = phase_i[P-2 -: D];
        v_c = phase_i[P-1] ? ~u_c : u_c;
        w_c = {~v_c[D-1], v_c[D-2:0]};
        case (mode_i)
            MODE_SQUARE: w_c = (phase_i < duty_i) ? {1'b0, {(D-1){1'b1}}}
                                                  : {1'b1, {(D-1){1'b0}}};
            MODE_SAW:    w_c = {~t_c[D-1], t_c[D-2:0]};
            default:     ;
        endcase
    end

    // Stage 1: capture waveform and the gain that belongs to this sample
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1   <= 1'b0;
            w1   <= '0;
            amp1 <= '0;
        end else begin
            v1   <= accept;
            w1   <= w_c;
            amp1 <= amp_i;
        end
    end

`ifdef FG_SINE_EN
    logic         sine1;
    logic         neg1;
    logic [P-3:0] sine_idx;
    logic [D-2:0] m1;
    logic [D-1:0] mag_ext;

    // Odd quadrants read the quarter wave mirrored
    assign sine_idx = phase_i[P-3:0] ^ {(P-2){phase_i[P-2]}};

    fg_sine_lut #(
        .IDX_BITWIDTH(P-2),
        .MAG_BITWIDTH(D-1)
    ) u_sine (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .idx_i (sine_idx),
        .mag_o (m1)
    );

    // Stage 1 sine controls travel alongside the ROM read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sine1 <= 1'b0;
            neg1  <= 1'b0;
        end else begin
            sine1 <= (mode_i == MODE_SINE);
            neg1  <= phase_i[P-1];
        end
    end

    assign mag_ext = {1'b0, m1};
    assign ws1     = sine1 ? (neg1 ? -mag_ext : mag_ext) : w1;
`else
    assign ws1 = w1;
`endif

    // Full-width signed product; amp is always non-negative
    assign prod = $signed({{(A+2){ws1[D-1]}}, ws1}) * $signed({{D{1'b0}}, amp1});

    // Stage 2: floor-shifted scaled sample plus offset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v2   <= 1'b0;
            s2   <= '0;
            off2 <= '0;
        end else begin
            v2   <= v1;
            s2   <= prod[A +: D+2];
            off2 <= offset_i;
        end
    end

    // Re-bias to unsigned and add the sign-extended offset
    assign r_c = {s2[D+1], s2} + {{3{off2[D-1]}}, off2} + MID;

    // Stage 3: saturate into the DAC code and pulse valid
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= MID[D-1:0];
        end else begin
            valid_o <= v2;
            if (v2) begin
                if (r_c[D+2])             data_o <= '0;
                else if (r_c[D+1:D] != 0) data_o <= '1;
                else                      data_o <= r_c[D-1:0];
            end
        end
    end

endmodule
